mioc_gate_sequencer: RTL and testbench

Self-checking on-chip pattern sequencer for MIOC MOS gate test structures. It drives all 16 combinations of a 4-input gate under test (`in1`..`in4`) and waits a programmable settle time. It then samples the gate output `z` through a synchronizer and compares it against a 16-bit golden truth table captured at start. Every observation streams out over a valid/ready port, and a pass/fail summary is held for readout. The block sits between the test-control register interface and the gate instance, replacing the file-driven stimulus used in simulation.

---
 rtl/mioc_gate_sequencer_if.sv | 10 +
 rtl/mioc_gate_sequencer.sv | 117 +++++++++++
 tb/tb_mioc_gate_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mioc_gate_sequencer_if.sv
// Observation stream from the gate sequencer: one {mismatch, pattern, z} record
// per handshake.
interface mioc_gate_sequencer_if;
  logic       obs_valid;
  logic       obs_ready;
  logic [5:0] obs_data;

  modport master (output obs_valid, output obs_data, input obs_ready);
  modport slave  (input obs_valid, input obs_data, output obs_ready);
endinterface

// File: rtl/mioc_gate_sequencer.sv
// Walks a 4-input MOS gate through all 16 input patterns and checks each
// settled output against a captured golden truth table.
module mioc_gate_sequencer #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  golden,
  input  logic                         z_in,
  output logic [3:0]                   drv,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [4:0]                   fail_count,
  output logic [15:0]                  fail_mask,
  mioc_gate_sequencer_if.master        obs
);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_t;

  // Counter runs S-1 down to 0, so SETTLE spans exactly S cycles.
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  pattern;
  logic [15:0] golden_q;
  logic        z_p0;
  logic        z_p1;

  // Synchronizer stage: z_in is asynchronous to clk
  always_ff @(posedge clk) begin
    if (rst) begin
      z_p0 <= 1'b0;
      z_p1 <= 1'b0;
    end else begin
      z_p0 <= z_in;
      z_p1 <= z_p0;
    end
  end

  always_ff @(posedge clk) begin
    golden_q <= golden_q;
    if (state == IDLE && start && !rst) begin
      golden_q <= golden;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      pattern       <= 4'd0;
      drv           <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_count    <= 5'd0;
      fail_mask     <= 16'd0;
      obs.obs_valid <= 1'b0;
      obs.obs_data  <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fail_count <= 5'd0;
            fail_mask  <= 16'd0;
            pass       <= 1'b0;
            pattern    <= 4'd0;
            drv        <= 4'd0;
            cnt        <= CNT_LOAD;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) begin
            obs.obs_data  <= {z_p1 ^ golden_q[pattern], pattern, z_p1};
            obs.obs_valid <= 1'b1;
            state         <= EMIT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        EMIT: begin
          if (obs.obs_ready) begin
            obs.obs_valid <= 1'b0;
            if (obs.obs_data[5]) begin
              fail_count         <= fail_count + 5'd1;
              fail_mask[pattern] <= 1'b1;
            end
            if (pattern == 4'd15) begin
              // Fold in the final pattern's verdict so pass is valid alongside done.
              pass  <= (fail_count == 5'd0) && !obs.obs_data[5];
              done  <= 1'b1;
              drv   <= 4'd0;
              state <= DONE;
            end else begin
              pattern <= pattern + 4'd1;
              drv     <= pattern + 4'd1;
              cnt     <= CNT_LOAD;
              state   <= SETTLE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mioc_gate_sequencer.sv
// Directed bench for mioc_gate_sequencer: nominal, stuck output, back-to-back,
// mid-run disturbance, mid-run reset and backpressure runs.
module tb_mioc_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stuck, obs_ready, sel;
  logic [15:0] golden;

  logic [3:0]  drv_a, drv_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b, z_a, z_b;
  logic [4:0]  fc_a, fc_b;
  logic [15:0] fm_a, fm_b;

  mioc_gate_sequencer_if ifa ();
  mioc_gate_sequencer_if ifb ();

  assign ifa.obs_ready = obs_ready;
  assign ifb.obs_ready = obs_ready;

  always #5 clk = ~clk;

  function automatic logic gate(input logic [3:0] d);
    return ~((d[3] & d[2]) | d[1] | d[0]);
  endfunction

  assign z_a = stuck ? 1'b0 : gate(drv_a);
  assign z_b = stuck ? 1'b0 : gate(drv_b);

  mioc_gate_sequencer #(.SETTLE_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .golden(golden), .z_in(z_a),
    .drv(drv_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fc_a), .fail_mask(fm_a), .obs(ifa.master)
  );

  mioc_gate_sequencer #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .golden(golden), .z_in(z_b),
    .drv(drv_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fc_b), .fail_mask(fm_b), .obs(ifb.master)
  );

  logic [3:0]  drv_s;
  logic        busy_s, done_s, pass_s, valid_s;
  logic [4:0]  fc_s;
  logic [15:0] fm_s;
  logic [5:0]  data_s;

  assign drv_s   = sel ? drv_b  : drv_a;
  assign busy_s  = sel ? busy_b : busy_a;
  assign done_s  = sel ? done_b : done_a;
  assign pass_s  = sel ? pass_b : pass_a;
  assign fc_s    = sel ? fc_b   : fc_a;
  assign fm_s    = sel ? fm_b   : fm_a;
  assign valid_s = sel ? ifb.obs_valid : ifa.obs_valid;
  assign data_s  = sel ? ifb.obs_data  : ifa.obs_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_test(input string tag, input logic use_b, input logic [15:0] g,
                          input logic stk, input logic disturb, input int stall,
                          input int exp_done, input logic exp_pass,
                          input logic [4:0] exp_fc, input logic [15:0] exp_fm);
    int cyc, nobs, st;
    logic [5:0] held, exp_obs;
    logic [3:0] hdrv, p;
    logic       ze;
    sel = use_b; stuck = stk; golden = g; obs_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy1"}, busy_s, 1'b1);
    chk({tag, "_clr_pass"}, pass_s, 1'b0);
    chk({tag, "_clr_fc"}, fc_s, 5'd0);
    chk({tag, "_clr_fm"}, fm_s, 16'd0);
    cyc = 1; nobs = 0; st = 0; held = '0; hdrv = '0;
    while (!done_s && cyc < 3000) begin
      if (disturb && cyc == 20) begin
        start = 1'b1;
        golden = ~g;
      end else if (disturb && cyc == 21) begin
        start = 1'b0;
      end
      obs_ready = 1'b1;
      if (valid_s) begin
        if (st < stall) begin
          if (st == 0) begin
            held = data_s;
            hdrv = drv_s;
          end else begin
            chk({tag, "_stall_data"}, data_s, held);
            chk({tag, "_stall_drv"}, drv_s, hdrv);
          end
          obs_ready = 1'b0;
          st++;
        end else begin
          p = nobs[3:0];
          ze = stk ? 1'b0 : gate(p);
          exp_obs = {ze ^ g[nobs], p, ze};
          chk({tag, "_obs"}, data_s, exp_obs);
          chk({tag, "_obs_drv"}, drv_s, p);
          st = 0;
          nobs++;
        end
      end
      step();
      cyc++;
    end
    obs_ready = 1'b1;
    chk({tag, "_done_cycle"}, cyc, exp_done);
    chk({tag, "_nobs"}, nobs, 16);
    chk({tag, "_done_drv"}, drv_s, 4'd0);
    chk({tag, "_pass"}, pass_s, exp_pass);
    chk({tag, "_fail_count"}, fc_s, exp_fc);
    chk({tag, "_fail_mask"}, fm_s, exp_fm);
    step();
    chk({tag, "_done_pulse"}, done_s, 1'b0);
    chk({tag, "_busy_end"}, busy_s, 1'b0);
  endtask

  int ndone;

  initial begin
    rst = 1'b1; start = 1'b0; golden = 16'h0; stuck = 1'b0; obs_ready = 1'b1; sel = 1'b0;
    repeat (3) step();
    chk("rst_drv", drv_a, 4'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_valid", ifa.obs_valid, 1'b0);
    chk("rst_data", ifa.obs_data, 6'd0);
    chk("rst_pass", pass_a, 1'b0);
    chk("rst_fc", fc_a, 5'd0);
    chk("rst_fm", fm_a, 16'd0);
    rst = 1'b0;
    step();

    run_test("nominal", 1'b0, 16'h0111, 1'b0, 1'b0, 0, 145, 1'b1, 5'd0, 16'h0000);
    run_test("b2b",     1'b0, 16'hFFFF, 1'b0, 1'b0, 0, 145, 1'b0, 5'd13, 16'hFEEE);
    run_test("stuck",   1'b0, 16'h0111, 1'b1, 1'b0, 0, 145, 1'b0, 5'd3, 16'h0111);
    run_test("disturb", 1'b0, 16'h0111, 1'b0, 1'b1, 0, 145, 1'b1, 5'd0, 16'h0000);

    // Reset during pattern 7 SETTLE (cycles 64..71 with S=8)
    sel = 1'b0; golden = 16'h0111; stuck = 1'b0; obs_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    repeat (65) begin
      if (done_a) ndone++;
      step();
    end
    chk("mr_drv7", drv_a, 4'd7);
    chk("mr_busy", busy_a, 1'b1);
    rst = 1'b1;
    step();
    chk("mr_drv", drv_a, 4'd0);
    chk("mr_busy0", busy_a, 1'b0);
    chk("mr_done", done_a, 1'b0);
    chk("mr_valid", ifa.obs_valid, 1'b0);
    chk("mr_data", ifa.obs_data, 6'd0);
    chk("mr_pass", pass_a, 1'b0);
    chk("mr_fc", fc_a, 5'd0);
    chk("mr_fm", fm_a, 16'd0);
    rst = 1'b0;
    repeat (20) begin
      if (done_a) ndone++;
      step();
    end
    chk("mr_no_done", ndone, 0);
    run_test("after_rst", 1'b0, 16'h0111, 1'b0, 1'b0, 0, 145, 1'b1, 5'd0, 16'h0000);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    run_test("backpressure", 1'b1, 16'h0111, 1'b0, 1'b0, 5, 145, 1'b1, 5'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
